// File: rtl/fixed_accum_if.sv
// -----------------------------------------------------------------------------
// fixed_accum_if
// Handshake bundle between a Q8.8 product source, the fixed_accum stage and
// the downstream result consumer.
//
//   IN_VALID  : source -> stage, IN_DATA/IN_LAST valid
//   IN_READY  : stage  -> source, stage accepts a term this cycle
//   IN_DATA   : source -> stage, signed product term (bits wide)
//   IN_LAST   : source -> stage, final term of the group
//   OUT_VALID : stage  -> consumer, group result available
//   OUT_READY : consumer -> stage, consumer takes the result
//   OUT_DATA  : stage  -> consumer, signed saturated group sum (bits wide)
//   OUT_SAT   : stage  -> consumer, saturation occurred in this group
//   OUT_CNT   : stage  -> consumer, number of terms in group (saturating)
//
// Modports: slave is the accumulator's view, master is the environment's view
// (term producer plus result consumer).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface fixed_accum_if #(
    parameter int bits  = 16,
    parameter int CNT_W = 8
);
    logic             IN_VALID;
    logic             IN_READY;
    logic [bits-1:0]  IN_DATA;
    logic             IN_LAST;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [bits-1:0]  OUT_DATA;
    logic             OUT_SAT;
    logic [CNT_W-1:0] OUT_CNT;

    modport slave (
        input  IN_VALID, IN_DATA, IN_LAST, OUT_READY,
        output IN_READY, OUT_VALID, OUT_DATA, OUT_SAT, OUT_CNT
    );

    modport master (
        output IN_VALID, IN_DATA, IN_LAST, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_DATA, OUT_SAT, OUT_CNT
    );
endinterface

// File: rtl/fixed_accum.sv
// -----------------------------------------------------------------------------
// fixed_accum
// Accumulates a group of signed fixed-point product terms (Q8.8 by default)
// into a wide accumulator with GUARD extra MSBs, and emits one saturated
// result per group on a valid/ready handshake.
//
// Ports:
//   CLK   : clock, rising edge
//   RSTN  : asynchronous active-low reset
//   CLR   : synchronous clear/abort of the current group
//   bus   : fixed_accum_if.slave (term input and result output handshakes)
//
// Parameters:
//   bits  : term/result width
//   GUARD : extra accumulator MSBs (accumulator width = bits + GUARD)
//   CNT_W : width of the saturating term counter
//
// Build option:
//   FIXED_ACCUM_RELU_EN : when defined, a negative final sum is reported as
//                         zero; OUT_SAT still reflects the pre-ReLU sum only.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module fixed_accum #(
    parameter int bits  = 16,
    parameter int GUARD = 8,
    parameter int CNT_W = 8
) (
    input  logic CLK,
    input  logic RSTN,
    input  logic CLR,
    fixed_accum_if.slave bus
);

    localparam int ACC_W = bits + GUARD;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t           state_q;
    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sat_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [bits-1:0]  out_data_q;
    logic             out_sat_q;
    logic [CNT_W-1:0] out_cnt_q;

    logic [ACC_W:0]   sum_wide;
    logic             acc_ovf;
    logic [ACC_W-1:0] acc_d;
    logic [GUARD:0]   acc_top;
    logic             out_clamp;
    logic [bits-1:0]  clamped;
    logic [bits-1:0]  out_data_d;
    logic [CNT_W-1:0] cnt_d;
    logic             accept;

    always_comb begin
        // One extra bit above the accumulator exposes signed overflow as a
        // disagreement between the two top bits of the sum.
        sum_wide = {acc_q[ACC_W-1], acc_q}
                 + {{(GUARD + 1){bus.IN_DATA[bits-1]}}, bus.IN_DATA};
        acc_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];

        if (acc_ovf) begin
            acc_d = sum_wide[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}}
                                    : {1'b0, {(ACC_W - 1){1'b1}}};
        end else begin
            acc_d = sum_wide[ACC_W-1:0];
        end

        // The result fits in bits when every bit from the output sign bit
        // upward is a copy of the accumulator sign.
        acc_top   = acc_d[ACC_W-1:bits-1];
        out_clamp = !((&acc_top) || !(|acc_top));

        if (out_clamp) begin
            clamped = acc_d[ACC_W-1] ? {1'b1, {(bits - 1){1'b0}}}
                                     : {1'b0, {(bits - 1){1'b1}}};
        end else begin
            clamped = acc_d[bits-1:0];
        end

`ifdef FIXED_ACCUM_RELU_EN
        out_data_d = acc_d[ACC_W-1] ? '0 : clamped;
`else
        out_data_d = clamped;
`endif

        cnt_d  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        accept = bus.IN_VALID && in_ready_q && (state_q == ST_ACC);
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= ST_ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            out_cnt_q   <= '0;
        end else if (CLR) begin
            // Abort the group; the last delivered result stays readable.
            state_q     <= ST_ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        if (bus.IN_LAST) begin
                            out_data_q  <= out_data_d;
                            out_sat_q   <= sat_q | acc_ovf | out_clamp;
                            out_cnt_q   <= cnt_d;
                            out_valid_q <= 1'b1;
                            in_ready_q  <= 1'b0;
                            state_q     <= ST_DONE;
                        end else begin
                            acc_q <= acc_d;
                            cnt_q <= cnt_d;
                            sat_q <= sat_q | acc_ovf;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.OUT_READY) begin
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        sat_q       <= 1'b0;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_ACC;
                    end
                end
                default: begin
                    state_q <= ST_ACC;
                end
            endcase
        end
    end

    assign bus.IN_READY  = in_ready_q;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.OUT_DATA  = out_data_q;
    assign bus.OUT_SAT   = out_sat_q;
    assign bus.OUT_CNT   = out_cnt_q;

endmodule

// File: doc/fixed_accum.md
Name: fixed_accum

Overview:
- Q8.8 accumulate stage directly downstream of the registered fixed-point multiplier; consumes its 16-bit product stream and sums one group of terms (e.g. a dot-product row).
- Group end is marked by IN_LAST; emits one saturated Q8.8 result per group on a valid/ready output handshake.
- Wide internal accumulator with guard bits; saturation flag reported per group.

Parameters:
- bits, 16, data width of IN_DATA/OUT_DATA (Q8.8 at default)
- GUARD, 8, extra accumulator MSBs; accumulator width = bits+GUARD
- CNT_W, 8, width of term counter OUT_CNT

Ports:
- CLK  input  1  clock, rising edge
- RSTN  input  1  asynchronous active-low reset
- CLR  input  1  synchronous clear/abort of current group
- IN_VALID  input  1  IN_DATA/IN_LAST valid
- IN_READY  output  1  stage accepts a term this cycle
- IN_DATA  input  bits  signed Q8.8 product term
- IN_LAST  input  1  final term of group
- OUT_VALID  output  1  result available
- OUT_READY  input  1  consumer accepts result
- OUT_DATA  output  bits  signed saturated group sum
- OUT_SAT  output  1  saturation occurred in this group
- OUT_CNT  output  CNT_W  number of terms in group (saturating)

Behaviour:
- Reset (RSTN=0, async): state=ACC, acc=0, cnt=0, sat flag=0; OUT_VALID=0, OUT_DATA=0, OUT_SAT=0, OUT_CNT=0. IN_READY=1 from first edge after release.
- Two states: ACC and DONE. IN_READY=1 only in ACC; OUT_VALID=1 only in DONE.
- ACC, term accepted (IN_VALID & IN_READY): next = acc + sign-extended IN_DATA, saturated to accumulator width; cnt increments, holds at 2^CNT_W-1; sat flag ORs in any saturation.
  - If IN_LAST=0: acc <= next, stay ACC.
  - If IN_LAST=1: OUT_DATA <= next clamped to [0x8000, 0x7FFF] (generally -2^(bits-1) .. 2^(bits-1)-1); OUT_SAT <= sat flag | accumulator sat | output clamp; OUT_CNT <= cnt+1 (saturating); go DONE. Latency: OUT_VALID high the cycle after the last term is accepted.
- ACC, IN_VALID=0: hold all state.
- DONE: OUT_DATA/OUT_SAT/OUT_CNT held stable while OUT_READY=0; IN_VALID ignored. On OUT_READY=1: acc=0, cnt=0, sat flag=0, return to ACC. OUT_DATA/OUT_SAT/OUT_CNT keep their last values; only OUT_VALID drops. Throughput: one group per N+1 cycles minimum.
- Single-term group (IN_LAST on first term): OUT_DATA = that term, OUT_CNT=1.
- CLR=1: highest priority after reset. Next edge: acc=0, cnt=0, sat flag=0, OUT_VALID=0, state=ACC. The term presented in the same cycle is discarded. Result registers are not cleared.
- Arithmetic: two's complement, no rounding (Q8.8 sums are exact); only saturation alters values.

Optional Feature:
- FIXED_ACCUM_RELU_EN defined: a negative final sum is replaced by 0x0000 in OUT_DATA. OUT_SAT still reflects saturation of the pre-ReLU sum; ReLU clamping alone does not set OUT_SAT.
- Undefined: OUT_DATA is the signed saturated sum.

Test Plan:
- Reset: assert RSTN=0 mid-group after 2 terms -> OUT_VALID=0, OUT_DATA=0, OUT_CNT=0. After release, IN_READY=1; a new group 0x0100 with LAST -> OUT_DATA=0x0100, OUT_CNT=1.
- Basic group: 0x0100, 0x0280, 0xFF00 (LAST on third) -> one cycle later OUT_VALID=1, OUT_DATA=0x0280, OUT_CNT=3, OUT_SAT=0.
- Saturation: four terms 0x7000 -> OUT_DATA=0x7FFF, OUT_SAT=1. Next group, four terms 0x9000 -> OUT_DATA=0x8000, OUT_SAT=1.
- Backpressure: hold OUT_READY=0 for 5 cycles with IN_VALID=1, data 0x0500 -> IN_READY=0, OUT_DATA stable. Release -> next group 0x0100 LAST gives OUT_DATA=0x0100 (no carry-over).
- CLR: accept 0x0300, 0x0300, then CLR=1 with IN_VALID=1, data 0x0400 -> discarded. Then 0x0100 LAST -> OUT_DATA=0x0100, OUT_CNT=1.
- Optional feature: group 0xFF00, 0xFE80 (sum -2.5) -> OUT_DATA=0x0000 with FIXED_ACCUM_RELU_EN, 0xFD80 without; OUT_SAT=0 in both cases.
